// File: rtl/dynamics_gain_ctrl_pkg.sv
// Shared types and constants for the dynamics sidechain gain computer.
package dynamics_gain_ctrl_pkg;

  localparam int         LVL_W      = 5;
  localparam logic [7:0] UNITY_GAIN = 8'h80;
  localparam logic [7:0] MIN_GAIN   = 8'h01;
  localparam logic [15:0] MAG_MAX   = 16'h7FFF;

  // One cycle per state; IDLE is the only non-busy state.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ABS  = 3'd1,
    ST_ENV  = 3'd2,
    ST_GAIN = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  // Magnitude of a 2's complement sample; -32768 clamps to 32767 so the
  // envelope always fits in 15 bits.
  function automatic logic [15:0] abs_sat(input logic [15:0] s);
    logic [15:0] r;
    if (s == 16'h8000) begin
      r = MAG_MAX;
    end else if (s[15]) begin
      r = 16'(~s + 16'd1);
    end else begin
      r = s;
    end
    return r;
  endfunction

endpackage

// File: rtl/dynamics_gain_ctrl_if.sv
// Sample/control/gain bundle between the sample source and the gain computer.
interface dynamics_gain_ctrl_if;
  import dynamics_gain_ctrl_pkg::*;

  logic [15:0]      sample_in;
  logic             sample_valid;
  logic [4:0]       start;
  logic [1:0]       ratio_sel;
  logic [3:0]       attack_shift;
  logic [3:0]       release_shift;
  logic             bypass;
  logic [7:0]       multiple;
  logic [LVL_W-1:0] curr;
  logic             gain_valid;
  logic             busy;

  modport master (
    output sample_in, sample_valid, start, ratio_sel,
           attack_shift, release_shift, bypass,
    input  multiple, curr, gain_valid, busy
  );

  modport slave (
    input  sample_in, sample_valid, start, ratio_sel,
           attack_shift, release_shift, bypass,
    output multiple, curr, gain_valid, busy
  );

endinterface

// File: rtl/dynamics_gain_ctrl_level_detect.sv
// Envelope to level index: 0 for silence, else (MSB position + 1).
module dynamics_gain_ctrl_level_detect
  import dynamics_gain_ctrl_pkg::*;
(
  input  logic [15:0]      env,
  output logic [LVL_W-1:0] lvl
);

  // Upward scan so the highest set bit is the last one to write lvl.
  always_comb begin
    lvl = {LVL_W{1'b0}};
    for (int i = 0; i < 16; i++) begin
      if (env[i]) begin
        lvl = LVL_W'(i + 1);
      end else begin
        lvl = lvl;
      end
    end
  end

endmodule

// File: rtl/dynamics_gain_ctrl.sv
// Sidechain gain computer: peak envelope -> log2 level -> ratio -> smoothed
// Q1.7 gain, one update per accepted sample, four cycles of latency.
module dynamics_gain_ctrl
  import dynamics_gain_ctrl_pkg::*;
#(
  parameter int unsigned ATT_STEP = 8,
  parameter int unsigned REL_STEP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  dynamics_gain_ctrl_if.slave  bus
);

  localparam logic [7:0] ATT_V = 8'(ATT_STEP);
  localparam logic [7:0] REL_V = 8'(REL_STEP);

  state_t           state_r, next_state_s;
  logic [15:0]      sample_r;
  logic [4:0]       start_r;
  logic [1:0]       ratio_r;
  logic [3:0]       att_sh_r, rel_sh_r;
  logic             bypass_r;
  logic [15:0]      mag_r, env_r, env_next_s;
  logic [LVL_W-1:0] lvl_s, over_s, atten_s;
  logic [7:0]       target_s, mult_next_s;
  logic [7:0]       multiple_r;
  logic [LVL_W-1:0] curr_r;
  logic             gain_valid_r, busy_r;
  logic             gain_valid_nxt_s, busy_nxt_s;
  logic             accept_s;

  assign accept_s = (state_r == ST_IDLE) && bus.sample_valid;

  // State register; reset drops any update in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Fixed walk through the pipeline once a sample is accepted.
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (bus.sample_valid) begin
          next_state_s = ST_ABS;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ABS:  next_state_s = ST_ENV;
      ST_ENV:  next_state_s = ST_GAIN;
      ST_GAIN: next_state_s = ST_OUT;
      ST_OUT:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Next values for the registered handshake outputs.
  always_comb begin
    busy_nxt_s       = (next_state_s != ST_IDLE);
    gain_valid_nxt_s = 1'b0;
    case (state_r)
      ST_GAIN: gain_valid_nxt_s = 1'b1;
      default: gain_valid_nxt_s = 1'b0;
    endcase
  end

  // Sample and control snapshot; later input changes wait for the next sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sample_r <= 16'd0;
      start_r  <= 5'd0;
      ratio_r  <= 2'd0;
      att_sh_r <= 4'd0;
      rel_sh_r <= 4'd0;
      bypass_r <= 1'b0;
    end else if (accept_s) begin
      sample_r <= bus.sample_in;
      start_r  <= bus.start;
      ratio_r  <= bus.ratio_sel;
      att_sh_r <= bus.attack_shift;
      rel_sh_r <= bus.release_shift;
      bypass_r <= bus.bypass;
    end
  end

  // Rectify the captured sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mag_r <= 16'd0;
    end else if (state_r == ST_ABS) begin
      mag_r <= abs_sat(sample_r);
    end
  end

  // Peak follower: fast rise toward the magnitude, geometric decay otherwise.
  // The rise never passes mag, so env stays within 15 bits.
  always_comb begin
    if (mag_r > env_r) begin
      env_next_s = env_r + ((mag_r - env_r) >> att_sh_r);
    end else begin
      env_next_s = env_r - (env_r >> rel_sh_r);
    end
  end

  // Envelope register, updated once per sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      env_r <= 16'd0;
    end else if (state_r == ST_ENV) begin
      env_r <= env_next_s;
    end
  end

  dynamics_gain_ctrl_level_detect u_level_detect (
    .env (env_r),
    .lvl (lvl_s)
  );

  // Excess level over threshold, scaled by the ratio, mapped to a target gain.
  always_comb begin
    if (lvl_s > start_r) begin
      over_s = lvl_s - start_r;
    end else begin
      over_s = {LVL_W{1'b0}};
    end
    case (ratio_r)
      2'd0:    atten_s = over_s - over_s;
      2'd1:    atten_s = over_s - (over_s >> 1);
      2'd2:    atten_s = over_s - (over_s >> 2);
      2'd3:    atten_s = over_s;
      default: atten_s = over_s;
    endcase
    if (atten_s >= 5'd7) begin
      target_s = MIN_GAIN;
    end else begin
      target_s = UNITY_GAIN >> atten_s;
    end
  end

  // Slew-limited step toward target; clamps at target so it never overshoots.
  always_comb begin
    if (bypass_r) begin
      mult_next_s = UNITY_GAIN;
    end else if (target_s < multiple_r) begin
      if ((multiple_r - target_s) > ATT_V) begin
        mult_next_s = multiple_r - ATT_V;
      end else begin
        mult_next_s = target_s;
      end
    end else if (target_s > multiple_r) begin
      if ((target_s - multiple_r) > REL_V) begin
        mult_next_s = multiple_r + REL_V;
      end else begin
        mult_next_s = target_s;
      end
    end else begin
      mult_next_s = multiple_r;
    end
  end

  // Gain/level outputs land together with gain_valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      multiple_r <= UNITY_GAIN;
      curr_r     <= {LVL_W{1'b0}};
    end else if (state_r == ST_GAIN) begin
      multiple_r <= mult_next_s;
      curr_r     <= lvl_s;
    end
  end

  // Registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gain_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      gain_valid_r <= gain_valid_nxt_s;
      busy_r       <= busy_nxt_s;
    end
  end

  assign bus.multiple   = multiple_r;
  assign bus.curr       = curr_r;
  assign bus.gain_valid = gain_valid_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_dynamics_gain_ctrl.sv
// Self-checking bench for dynamics_gain_ctrl against a behavioural model.
module tb_dynamics_gain_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  dynamics_gain_ctrl_if bus();

  dynamics_gain_ctrl #(.ATT_STEP(8), .REL_STEP(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_env;
  int m_mult;
  int m_curr;

  function automatic void model_reset();
    m_env  = 0;
    m_mult = 128;
    m_curr = 0;
  endfunction

  function automatic void model_update(input logic [15:0] s, input int st, input int rs,
                                       input int as_, input int rls, input logic byp);
    shortint ss;
    int mag, over, atten, target;
    ss  = s;
    mag = ss;
    if (mag < 0) mag = -mag;
    if (mag > 32767) mag = 32767;
    if (mag > m_env) m_env = m_env + ((mag - m_env) >> as_);
    else             m_env = m_env - (m_env >> rls);
    m_curr = (m_env == 0) ? 0 : $clog2(m_env + 1);
    over = (m_curr > st) ? m_curr - st : 0;
    case (rs)
      0: atten = 0;
      1: atten = over - over / 2;
      2: atten = over - over / 4;
      default: atten = over;
    endcase
    target = (atten >= 7) ? 1 : 128 / (1 << atten);
    if (byp) m_mult = 128;
    else if (target < m_mult) m_mult = (m_mult - 8 > target) ? m_mult - 8 : target;
    else if (target > m_mult) m_mult = (m_mult + 1 < target) ? m_mult + 1 : target;
  endfunction

  // Drive one sample, wait (bounded) for its gain_valid, return at idle.
  task automatic apply_sample(input logic [15:0] s, input int st, input int rs, input int as_,
                              input int rls, input logic byp, input logic scramble,
                              output int lat, output int mult, output int cur);
    bus.sample_in     = s;
    bus.start         = 5'(st);
    bus.ratio_sel     = 2'(rs);
    bus.attack_shift  = 4'(as_);
    bus.release_shift = 4'(rls);
    bus.bypass        = byp;
    bus.sample_valid  = 1'b1;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    if (scramble) begin
      bus.sample_in     = 16'($urandom);
      bus.start         = 5'($urandom);
      bus.ratio_sel     = 2'($urandom);
      bus.attack_shift  = 4'($urandom);
      bus.release_shift = 4'($urandom);
      bus.bypass        = 1'($urandom);
    end
    lat = -1; mult = -1; cur = -1;
    for (int k = 2; k <= 8 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (bus.gain_valid === 1'b1) begin
        lat  = k;
        mult = int'(bus.multiple);
        cur  = int'(bus.curr);
      end
    end
    if (lat >= 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_in = 16'd0; bus.start = 5'd0; bus.ratio_sel = 2'd0;
    bus.attack_shift = 4'd0; bus.release_shift = 4'd0; bus.bypass = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    total++; if (bus.multiple !== 8'h80) begin bad++; $display("FAIL reset_multiple: got %0h want 80", bus.multiple); end
    total++; if (bus.curr !== 5'd0) begin bad++; $display("FAIL reset_curr: got %0d want 0", bus.curr); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    total++; if (bus.gain_valid !== 1'b0) begin bad++; $display("FAIL reset_gain_valid: got %0b want 0", bus.gain_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_compress();
    int lat, mult, cur;
    for (int k = 1; k <= 14; k++) begin
      apply_sample(16'h1555, 10, 1, 0, 15, 1'b0, 1'b0, lat, mult, cur);
      model_update(16'h1555, 10, 1, 0, 15, 1'b0);
      total++; if (lat !== 4) begin bad++; $display("FAIL compress_latency[%0d]: got %0d want 4", k, lat); end
      total++; if (cur !== 13) begin bad++; $display("FAIL compress_curr[%0d]: got %0d want 13", k, cur); end
      total++; if (mult !== m_mult) begin bad++; $display("FAIL compress_multiple[%0d]: got %0h want %0h", k, mult, m_mult); end
      if (k == 1) begin
        total++; if (mult !== 32'h78) begin bad++; $display("FAIL compress_first: got %0h want 78", mult); end
      end
      if (k >= 12) begin
        total++; if (mult !== 32'h20) begin bad++; $display("FAIL compress_settled[%0d]: got %0h want 20", k, mult); end
      end
    end
  endtask

  task automatic test_release();
    int lat, mult, cur;
    for (int k = 1; k <= 100; k++) begin
      apply_sample(16'h0000, 10, 1, 0, 0, 1'b0, 1'b0, lat, mult, cur);
      model_update(16'h0000, 10, 1, 0, 0, 1'b0);
      total++; if (cur !== 0) begin bad++; $display("FAIL release_curr[%0d]: got %0d want 0", k, cur); end
      total++; if (mult !== m_mult) begin bad++; $display("FAIL release_multiple[%0d]: got %0h want %0h", k, mult, m_mult); end
      if (k == 1) begin
        total++; if (mult !== 32'h21) begin bad++; $display("FAIL release_first: got %0h want 21", mult); end
      end
    end
    total++; if (bus.multiple !== 8'h80) begin bad++; $display("FAIL release_final: got %0h want 80", bus.multiple); end
  endtask

  task automatic test_limit();
    int lat, mult, cur;
    for (int k = 1; k <= 18; k++) begin
      apply_sample(16'h8000, 10, 3, 0, 15, 1'b0, 1'b0, lat, mult, cur);
      model_update(16'h8000, 10, 3, 0, 15, 1'b0);
      total++; if (cur !== 15) begin bad++; $display("FAIL limit_curr[%0d]: got %0d want 15", k, cur); end
      total++; if (mult !== m_mult) begin bad++; $display("FAIL limit_multiple[%0d]: got %0h want %0h", k, mult, m_mult); end
    end
    total++; if (bus.multiple !== 8'h04) begin bad++; $display("FAIL limit_settled: got %0h want 04", bus.multiple); end
  endtask

  task automatic test_busy_drop();
    int pulses, first, cur, lat, mult, cur2;
    bus.sample_in = 16'h0000; bus.start = 5'd10; bus.ratio_sel = 2'd1;
    bus.attack_shift = 4'd0; bus.release_shift = 4'd0; bus.bypass = 1'b0;
    bus.sample_valid = 1'b1;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    model_update(16'h0000, 10, 1, 0, 0, 1'b0);
    @(posedge clk); #1;
    bus.sample_in = 16'h7FFF;
    bus.sample_valid = 1'b1;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    pulses = (bus.gain_valid === 1'b1) ? 1 : 0;
    first = -1; cur = -1;
    for (int k = 4; k <= 10; k++) begin
      @(posedge clk); #1;
      if (bus.gain_valid === 1'b1) begin
        pulses++;
        if (first < 0) begin first = k; cur = int'(bus.curr); end
      end
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL busy_drop_pulses: got %0d want 1", pulses); end
    total++; if (first !== 4) begin bad++; $display("FAIL busy_drop_latency: got %0d want 4", first); end
    total++; if (cur !== m_curr) begin bad++; $display("FAIL busy_drop_curr: got %0d want %0d", cur, m_curr); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL busy_drop_idle: got %0b want 0", bus.busy); end
    apply_sample(16'h0000, 10, 1, 0, 15, 1'b0, 1'b0, lat, mult, cur2);
    model_update(16'h0000, 10, 1, 0, 15, 1'b0);
    total++; if (cur2 !== m_curr) begin bad++; $display("FAIL busy_drop_env: got %0d want %0d", cur2, m_curr); end
  endtask

  task automatic test_bypass_abort();
    int lat, mult, cur, seen;
    for (int k = 1; k <= 3; k++) begin
      apply_sample(16'h1555, 10, 1, 0, 15, 1'b1, 1'b0, lat, mult, cur);
      model_update(16'h1555, 10, 1, 0, 15, 1'b1);
      total++; if (mult !== 32'h80) begin bad++; $display("FAIL bypass_multiple[%0d]: got %0h want 80", k, mult); end
      total++; if (cur !== 13) begin bad++; $display("FAIL bypass_curr[%0d]: got %0d want 13", k, cur); end
    end
    bus.bypass = 1'b0;
    bus.sample_in = 16'h7000;
    bus.sample_valid = 1'b1;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    seen = (bus.gain_valid === 1'b1) ? 1 : 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.gain_valid === 1'b1) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_gain_valid: got %0d pulses want 0", seen); end
    total++; if (bus.multiple !== 8'h80) begin bad++; $display("FAIL abort_multiple: got %0h want 80", bus.multiple); end
    total++; if (bus.curr !== 5'd0) begin bad++; $display("FAIL abort_curr: got %0d want 0", bus.curr); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %0b want 0", bus.busy); end
  endtask

  task automatic test_random();
    int lat, mult, cur, st, rs, as_, rls;
    logic [15:0] s;
    logic byp;
    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 4))
        0: s = 16'h8000;
        1: s = 16'($urandom_range(0, 255));
        default: s = 16'($urandom);
      endcase
      st  = $urandom_range(0, 20);
      rs  = $urandom_range(0, 3);
      as_ = $urandom_range(0, 4);
      rls = $urandom_range(0, 15);
      byp = ($urandom_range(0, 7) == 0);
      apply_sample(s, st, rs, as_, rls, byp, 1'b1, lat, mult, cur);
      model_update(s, st, rs, as_, rls, byp);
      total++; if (lat !== 4) begin bad++; $display("FAIL random_latency[%0d]: got %0d want 4", k, lat); end
      total++; if (cur !== m_curr) begin bad++; $display("FAIL random_curr[%0d]: got %0d want %0d", k, cur, m_curr); end
      total++; if (mult !== m_mult) begin bad++; $display("FAIL random_multiple[%0d]: got %0h want %0h", k, mult, m_mult); end
    end
  endtask

  initial begin
    test_reset();
    test_compress();
    test_release();
    test_limit();
    test_busy_drop();
    test_bypass_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
